// File: rtl/cmp_sar_search.sv
// ---------------------------------------------------------------------------
// cmp_sar_search
//
// Successive-approximation search controller for an N-bit magnitude
// comparator. The comparator's A input holds an unknown value. This block
// recovers that value by driving trial operands on cmp_b, one bit at a time,
// starting from the MSB, and reading back the lt/gt/eq flags.
//
// Each trial keeps the bits already resolved and sets the bit under test.
//   gt : A is above the trial, so the bit under test stays set.
//   lt : A is below the trial, so the bit under test is cleared.
//   eq : the trial equals A, so the search ends early with a hit.
// Flags that are not one-hot abort the search and raise err.
//
// Parameters
//   N      : operand width; must match the comparator (N >= 1)
//   SETTLE : extra wait cycles between driving cmp_b and sampling the flags
//
// Ports
//   clk     in   single clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   begin a search (only looked at while idle)
//   cmp_b   out  registered trial operand to comparator B input
//   cmp_lt  in   comparator flag A < B
//   cmp_gt  in   comparator flag A > B
//   cmp_eq  in   comparator flag A == B
//   busy    out  high while a search is in progress
//   done    out  one-cycle completion pulse
//   result  out  searched value, held until the next accepted start
//   found   out  eq was seen during the search (valid with done, then held)
//   err     out  flags were not one-hot at a sample (valid with done, then held)
// ---------------------------------------------------------------------------
module cmp_sar_search #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] cmp_b,
    input  logic         cmp_lt,
    input  logic         cmp_gt,
    input  logic         cmp_eq,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         found,
    output logic         err
);

    // Counter and bit-index widths never drop to zero, even for SETTLE=0 or N=1.
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int KW = (N < 2) ? 1 : $clog2(N);

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
    localparam logic [KW-1:0] K_TOP       = KW'(N - 1);
    localparam logic [N-1:0]  ONE         = N'(1);
    localparam logic [N-1:0]  FIRST_TRIAL = ONE << (N - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    // With no settle time, a freshly driven trial is sampled on the very next edge.
    localparam logic [1:0] ST_AFTER_LOAD = (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;

    logic          flags_ok;
    logic [N-1:0]  kept;
    logic [N-1:0]  next_trial;

    // Decode the comparator response for the current trial.
    // The partial result only absorbs the trial when A is above it. The next
    // trial sets the next-lower bit on top of that updated partial result.
    // next_trial is only used while k > 0, so the k-1 wrap at k == 0 is harmless.
    always_comb begin
        flags_ok   = $onehot({cmp_lt, cmp_gt, cmp_eq});
        kept       = cmp_gt ? cmp_b : result;
        next_trial = kept | (ONE << (k - KW'(1)));
    end

    // Search sequencer.
    // IDLE accepts a start and launches the MSB trial.
    // WAIT lets the comparator settle for SETTLE cycles.
    // SAMPLE resolves one bit and either finishes or launches the next trial.
    // done defaults low so that it only ever lasts a single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            k      <= '0;
            cmp_b  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                        k      <= K_TOP;
                        cmp_b  <= FIRST_TRIAL;
                        busy   <= 1'b1;
                        cnt    <= SETTLE_LOAD;
                        state  <= ST_AFTER_LOAD;
                    end
                end

                ST_WAIT: begin
                    // Move on at the edge where the count reaches zero.
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                ST_SAMPLE: begin
                    if (!flags_ok) begin
                        // A broken comparator response leaves the partial result as is.
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cmp_eq) begin
                        result <= cmp_b;
                        found  <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        result <= kept;
                        if (k == '0) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            k     <= k - KW'(1);
                            cmp_b <= next_trial;
                            cnt   <= SETTLE_LOAD;
                            state <= ST_AFTER_LOAD;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sar_search.sv
// ---------------------------------------------------------------------------
// tb_cmp_sar_search
//
// Bench for cmp_sar_search. It uses two instances with N=4:
//   dut1 has SETTLE=1.
//   dut0 has SETTLE=0.
// Each instance is driven by a behavioural comparator model that looks at the
// shared unknown value a_val. The sel signal picks which instance a test
// drives and observes.
//
// Expected trials, result, found flag and latency come from the search rules:
//   - The search resolves bits from the MSB down to A's lowest set bit
//     (all N bits when A is zero).
//   - The trial for bit k is A's bits above k with bit k set.
//   - Each bit costs SETTLE+1 cycles.
// ---------------------------------------------------------------------------
module tb_cmp_sar_search;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start_drv;
    logic         sel;
    logic [N-1:0] a_val;
    logic         fault_en;
    logic [N-1:0] fault_trial;

    logic         start1, start0;
    logic [N-1:0] cmp_b1, cmp_b0, result1, result0;
    logic         busy1, busy0, done1, done0, found1, found0, err1, err0;
    logic         lt1, gt1, eq1, lt0, gt0, eq0;
    logic         inject1, inject0;

    int n_cmp = 0;
    int n_bad = 0;

    assign start1 = start_drv & sel;
    assign start0 = start_drv & ~sel;

    // Comparator models. When fault injection is enabled, lt and gt are both
    // forced high whenever the trial matches fault_trial.
    assign inject1 = fault_en && (cmp_b1 == fault_trial);
    assign inject0 = fault_en && (cmp_b0 == fault_trial);
    assign lt1 = (a_val < cmp_b1) | inject1;
    assign gt1 = (a_val > cmp_b1) | inject1;
    assign eq1 = (a_val == cmp_b1);
    assign lt0 = (a_val < cmp_b0) | inject0;
    assign gt0 = (a_val > cmp_b0) | inject0;
    assign eq0 = (a_val == cmp_b0);

    cmp_sar_search #(.N(N), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .cmp_b(cmp_b1),
        .cmp_lt(lt1), .cmp_gt(gt1), .cmp_eq(eq1), .busy(busy1), .done(done1),
        .result(result1), .found(found1), .err(err1)
    );

    cmp_sar_search #(.N(N), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .cmp_b(cmp_b0),
        .cmp_lt(lt0), .cmp_gt(gt0), .cmp_eq(eq0), .busy(busy0), .done(done0),
        .result(result0), .found(found0), .err(err0)
    );

    // View of whichever instance the current test has selected.
    logic [N-1:0] v_cmp_b, v_result;
    logic         v_busy, v_done, v_found, v_err;
    assign v_cmp_b  = sel ? cmp_b1  : cmp_b0;
    assign v_result = sel ? result1 : result0;
    assign v_busy   = sel ? busy1   : busy0;
    assign v_done   = sel ? done1   : done0;
    assign v_found  = sel ? found1  : found0;
    assign v_err    = sel ? err1    : err0;

    // Number of bits the search has to resolve before it finishes.
    function automatic int ref_bits(input logic [N-1:0] a);
        int av;
        av = int'(a);
        if (av == 0) return N;
        for (int b = 0; b < N; b++) begin
            if (((av >> b) & 1) == 1) return N - b;
        end
        return N;
    endfunction

    // Trial operand for the i-th bit resolved (i=0 is the MSB).
    function automatic logic [N-1:0] ref_trial(input logic [N-1:0] a, input int i);
        int k, av, t;
        k  = N - 1 - i;
        av = int'(a);
        t  = ((av >> (k + 1)) << (k + 1)) | (1 << k);
        return N'(t);
    endfunction

    // Start one search on the selected instance and check it cycle by cycle.
    // If extra_at is nonzero, start is also raised before edge E0+extra_at,
    // which lands while the search is still busy.
    task automatic run_search(input logic [N-1:0] a, input int extra_at, input string tag);
        int s, j, lat;
        s   = sel ? 1 : 0;
        j   = ref_bits(a);
        lat = j * (s + 1);
        a_val = a;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        n_cmp++;
        if (v_busy !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s busy_at_start: got %0b expected 1", tag, v_busy);
        end
        n_cmp++;
        if (v_cmp_b !== ref_trial(a, 0)) begin
            n_bad++;
            $display("[TB] FAIL %s first_trial: got %b expected %b", tag, v_cmp_b, ref_trial(a, 0));
        end
        for (int c = 1; c <= lat; c++) begin
            start_drv = (c == extra_at);
            @(posedge clk);
            #1;
            if (c < lat) begin
                n_cmp++;
                if (v_done !== 1'b0 || v_busy !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL %s early_end c=%0d: got done=%0b busy=%0b expected done=0 busy=1",
                             tag, c, v_done, v_busy);
                end
                n_cmp++;
                if (v_cmp_b !== ref_trial(a, c / (s + 1))) begin
                    n_bad++;
                    $display("[TB] FAIL %s trial c=%0d: got %b expected %b",
                             tag, c, v_cmp_b, ref_trial(a, c / (s + 1)));
                end
            end else begin
                n_cmp++;
                if (v_done !== 1'b1 || v_busy !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL %s completion c=%0d: got done=%0b busy=%0b expected done=1 busy=0",
                             tag, c, v_done, v_busy);
                end
                n_cmp++;
                if (v_result !== a || v_found !== (a != 0) || v_err !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL %s outcome: got result=%b found=%0b err=%0b expected result=%b found=%0b err=0",
                             tag, v_result, v_found, v_err, a, (a != 0));
                end
                n_cmp++;
                if (v_cmp_b !== ref_trial(a, j - 1)) begin
                    n_bad++;
                    $display("[TB] FAIL %s last_trial: got %b expected %b", tag, v_cmp_b, ref_trial(a, j - 1));
                end
            end
        end
        start_drv = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (v_done !== 1'b0 || v_busy !== 1'b0 || v_result !== a) begin
            n_bad++;
            $display("[TB] FAIL %s after_done: got done=%0b busy=%0b result=%b expected done=0 busy=0 result=%b",
                     tag, v_done, v_busy, v_result, a);
        end
    endtask

    // Reset: both instances must come up with every output at zero.
    task automatic test_reset();
        rst_n       = 1'b0;
        start_drv   = 1'b0;
        sel         = 1'b1;
        a_val       = '0;
        fault_en    = 1'b0;
        fault_trial = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmp_b1, result1, busy1, done1, found1, err1} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_dut1: got %b expected all zero", {cmp_b1, result1, busy1, done1, found1, err1});
        end
        n_cmp++;
        if ({cmp_b0, result0, busy0, done0, found0, err0} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_dut0: got %b expected all zero", {cmp_b0, result0, busy0, done0, found0, err0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Directed searches covering the hit, all-lt and all-ones cases.
    task automatic test_known();
        sel = 1'b1;
        run_search(4'b1010, 0, "known_1010");
        sel = 1'b0;
        run_search(4'b0000, 0, "known_0000");
        sel = 1'b1;
        run_search(4'b1111, 0, "known_1111");
    endtask

    // A start raised mid-search must not restart it. The per-cycle trial
    // checks would see the trial jump back to the MSB if it did.
    task automatic test_start_while_busy();
        sel = 1'b1;
        run_search(4'b0110, 3, "busy_start");
    endtask

    // Random values across both settle settings.
    task automatic test_random();
        logic [N-1:0] a;
        int extra;
        for (int i = 0; i < 16; i++) begin
            sel   = logic'($urandom_range(0, 1));
            a     = N'($urandom_range(0, 15));
            extra = ($urandom_range(0, 1) == 1) ? 2 : 0;
            run_search(a, extra, "random");
        end
    endtask

    // start held high: each done cycle accepts the next search, so done
    // pulses arrive every L+1 cycles.
    task automatic test_back_to_back();
        int c, seen, lat, want;
        sel   = 1'b1;
        a_val = 4'b1101;
        lat   = ref_bits(4'b1101) * 2;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        c    = 0;
        seen = 0;
        while (seen < 3 && c < 60) begin
            @(posedge clk);
            #1;
            c++;
            if (v_done === 1'b1) begin
                want = lat + seen * (lat + 1);
                n_cmp++;
                if (c != want) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_timing #%0d: got cycle %0d expected %0d", seen, c, want);
                end
                n_cmp++;
                if (v_result !== 4'b1101 || v_found !== 1'b1 || v_err !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL b2b_outcome #%0d: got result=%b found=%0b err=%0b expected 1101/1/0",
                             seen, v_result, v_found, v_err);
                end
                seen++;
            end
        end
        start_drv = 1'b0;
        n_cmp++;
        if (seen != 3) begin
            n_bad++;
            $display("[TB] FAIL b2b_count: got %0d done pulses expected 3", seen);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (v_busy !== 1'b0 || v_done !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL b2b_stop: got busy=%0b done=%0b expected 0/0", v_busy, v_done);
        end
    endtask

    // Both lt and gt forced on the second trial (1100, for A >= 8).
    // The search must abort with err=1 and the partial result 1000.
    task automatic test_fault();
        int c;
        bit seen;
        sel         = 1'b1;
        a_val       = 4'b1011;
        fault_trial = 4'b1100;
        fault_en    = 1'b1;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(posedge clk);
            #1;
            c++;
            if (v_done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || c != 4) begin
            n_bad++;
            $display("[TB] FAIL fault_timing: got seen=%0b cycle=%0d expected seen=1 cycle=4", seen, c);
        end
        n_cmp++;
        if (v_err !== 1'b1 || v_found !== 1'b0 || v_result !== 4'b1000 || v_busy !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL fault_outcome: got err=%0b found=%0b result=%b busy=%0b expected 1/0/1000/0",
                     v_err, v_found, v_result, v_busy);
        end
        fault_en = 1'b0;
        @(negedge clk);
        run_search(4'b0101, 0, "after_fault");
    endtask

    // Reset asserted during the second WAIT of A=0110. Everything must clear
    // at once and no done may appear. A fresh search afterwards must still work.
    task automatic test_reset_mid();
        int done_seen;
        sel   = 1'b1;
        a_val = 4'b0110;
        @(negedge clk);
        start_drv = 1'b1;
        @(posedge clk);
        #1;
        start_drv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmp_b1, result1, busy1, done1, found1, err1} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_clear: got %b expected all zero",
                     {cmp_b1, result1, busy1, done1, found1, err1});
        end
        done_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1) done_seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done1 === 1'b1) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_mid_no_done: got done pulses=%0d busy=%0b expected 0/0", done_seen, busy1);
        end
        run_search(4'b0110, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_known();
        test_start_while_busy();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of run expected finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
